hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding unit for the in-order pipeline, sitting beside the ID stage. It keeps a registered shadow of the destination registers in flight in the stages after ID. Each cycle it compares the ID-stage sources against that shadow and produces three outputs: a stall request, a per-source forwarding select, and a saturating stall-cycle performance counter. It supports two modes: forwarding enabled, where only load-use hazards stall, and forwarding disabled, where every RAW hazard stalls.

---
 rtl/hazard_scoreboard.sv | 136 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// Hazard detection and forwarding-select unit that sits beside the ID stage
// of an in-order pipeline. It keeps a registered shadow of the destination
// registers still in flight in the STAGES stages after ID. Each cycle it
// compares the ID-stage sources against that shadow.
//
// Parameters:
//   ADDR_W   register-file address width
//   STAGES   post-ID stages tracked (entry 0 = EXE, STAGES-1 = last before WB), 1..7
//   LOAD_LAT a load result is forwardable only from entry index >= LOAD_LAT
//   FWD_EN   1 = forwarding mode (only load-use stalls), 0 = stall on any RAW
//   CNT_W    stall counter width
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-low reset
//   src1, src1_valid     first ID source register and its "is read" flag
//   src2, two_src        second ID source register and its "is read" flag
//   id_wb_en, id_dest    ID instruction writes id_dest
//   id_mem_read          ID instruction is a load
//   freeze               whole-pipeline hold: entries and counter keep their values
//   flush                squash the ID instruction (bubble into entry 0)
//   hazard               stall request to IF/ID (combinational)
//   fwd_sel1, fwd_sel2   0 = register file, k = forward from entry k-1 (combinational)
//   stall_count          saturating count of cycles with hazard=1 and freeze=0
//
// There is no handshake and no FSM: the only state is the entry shift
// register and the counter.

module hazard_scoreboard #(
  parameter int ADDR_W   = 4,
  parameter int STAGES   = 2,
  parameter int LOAD_LAT = 1,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic              src1_valid,
  input  logic              two_src,
  input  logic              id_wb_en,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_mem_read,
  input  logic              freeze,
  input  logic              flush,
  output logic              hazard,
  output logic [2:0]        fwd_sel1,
  output logic [2:0]        fwd_sel2,
  output logic [CNT_W-1:0]  stall_count
);

  // Entry k models the instruction currently in post-ID stage k.
  logic [STAGES-1:0] ent_valid;
  logic [STAGES-1:0] ent_mem;
  logic [ADDR_W-1:0] ent_dest [STAGES];

  logic       hit1;
  logic       hit2;
  logic [2:0] sel1_raw;
  logic [2:0] sel2_raw;
  logic       ld_stall1;
  logic       ld_stall2;

  // Youngest-match search: scanning from the oldest entry down to entry 0
  // lets the lowest-index (youngest) writer overwrite any older match.
  // Everything here depends only on registered entries and ID inputs, so
  // hazard never feeds back combinationally into the compare.
  always_comb begin
    hit1      = 1'b0;
    hit2      = 1'b0;
    sel1_raw  = 3'd0;
    sel2_raw  = 3'd0;
    ld_stall1 = 1'b0;
    ld_stall2 = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (src1_valid && ent_valid[k] && (ent_dest[k] == src1)) begin
        hit1      = 1'b1;
        sel1_raw  = 3'(k + 1);
        ld_stall1 = ent_mem[k] && (k < LOAD_LAT);
      end
      if (two_src && ent_valid[k] && (ent_dest[k] == src2)) begin
        hit2      = 1'b1;
        sel2_raw  = 3'(k + 1);
        ld_stall2 = ent_mem[k] && (k < LOAD_LAT);
      end
    end
  end

  always_comb begin
    if (FWD_EN != 0) begin
      // Only a load that is still too young to forward stalls.
      hazard   = ld_stall1 | ld_stall2;
      fwd_sel1 = sel1_raw;
      fwd_sel2 = sel2_raw;
    end else begin
      // No forwarding network: any in-flight writer of a read source stalls.
      hazard   = hit1 | hit2;
      fwd_sel1 = 3'd0;
      fwd_sel2 = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid   <= '0;
      ent_mem     <= '0;
      for (int k = 0; k < STAGES; k++) begin
        ent_dest[k] <= '0;
      end
      stall_count <= '0;
    end else if (!freeze) begin
      for (int k = STAGES - 1; k > 0; k--) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_mem[k]   <= ent_mem[k-1];
        ent_dest[k]  <= ent_dest[k-1];
      end
      // A stalled or squashed ID instruction does not advance; entry 0
      // receives a bubble instead.
      if (!hazard && !flush) begin
        ent_valid[0] <= id_wb_en;
        ent_mem[0]   <= id_mem_read;
        ent_dest[0]  <= id_dest;
      end else begin
        ent_valid[0] <= 1'b0;
        ent_mem[0]   <= 1'b0;
        ent_dest[0]  <= '0;
      end
      if (hazard && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//
// Bench for hazard_scoreboard. Three instances share one set of ID inputs:
//   dut_a  default parameters (forwarding, STAGES=2, LOAD_LAT=1)
//   dut_b  FWD_EN=0, STAGES=3
//   dut_c  CNT_W=4 for counter saturation
// dsel picks which instance the checks observe. Each test group starts
// from a fresh reset so expected counter values are local to the group.

module tb_hazard_scoreboard;

  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic [AW-1:0] src1;
  logic [AW-1:0] src2;
  logic          src1_valid;
  logic          two_src;
  logic          id_wb_en;
  logic [AW-1:0] id_dest;
  logic          id_mem_read;
  logic          freeze;
  logic          flush;

  logic          haz_a, haz_b, haz_c;
  logic [2:0]    s1_a, s2_a, s1_b, s2_b, s1_c, s2_c;
  logic [15:0]   cnt_a, cnt_b;
  logic [3:0]    cnt_c;

  int            vec_count;
  int            miscompares;
  int            dsel;
  logic [22:0]   exp_q[$];

  hazard_scoreboard dut_a (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .src1_valid(src1_valid),
    .two_src(two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_mem_read(id_mem_read), .freeze(freeze), .flush(flush),
    .hazard(haz_a), .fwd_sel1(s1_a), .fwd_sel2(s2_a), .stall_count(cnt_a)
  );

  hazard_scoreboard #(.STAGES(3), .FWD_EN(0)) dut_b (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .src1_valid(src1_valid),
    .two_src(two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_mem_read(id_mem_read), .freeze(freeze), .flush(flush),
    .hazard(haz_b), .fwd_sel1(s1_b), .fwd_sel2(s2_b), .stall_count(cnt_b)
  );

  hazard_scoreboard #(.CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .src1_valid(src1_valid),
    .two_src(two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_mem_read(id_mem_read), .freeze(freeze), .flush(flush),
    .hazard(haz_c), .fwd_sel1(s1_c), .fwd_sel2(s2_c), .stall_count(cnt_c)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  task automatic idle();
    src1        = '0;
    src2        = '0;
    src1_valid  = 1'b0;
    two_src     = 1'b0;
    id_wb_en    = 1'b0;
    id_dest     = '0;
    id_mem_read = 1'b0;
    freeze      = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] d, input logic ld);
    id_wb_en    = 1'b1;
    id_dest     = d;
    id_mem_read = ld;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_now(input string tag, input logic h, input logic [2:0] e1,
                           input logic [2:0] e2, input logic [15:0] c);
    logic [22:0] e;
    logic        oh;
    logic [2:0]  o1;
    logic [2:0]  o2;
    logic [15:0] oc;
    exp_q.push_back({h, e1, e2, c});
    #2;
    e = exp_q.pop_front();
    case (dsel)
      0:       begin oh = haz_a; o1 = s1_a; o2 = s2_a; oc = cnt_a; end
      1:       begin oh = haz_b; o1 = s1_b; o2 = s2_b; oc = cnt_b; end
      default: begin oh = haz_c; o1 = s1_c; o2 = s2_c; oc = {12'd0, cnt_c}; end
    endcase
    check({tag, "_haz"},  32'(oh), 32'(e[22]));
    check({tag, "_sel1"}, 32'(o1), 32'(e[21:19]));
    check({tag, "_sel2"}, 32'(o2), 32'(e[18:16]));
    check({tag, "_cnt"},  32'(oc), 32'(e[15:0]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] rr;
    logic          h;
    logic [2:0]    s;
    int            exp_c;

    vec_count   = 0;
    miscompares = 0;
    dsel        = 0;
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state
    src1 = 4'd3; src1_valid = 1'b1;
    check_now("rst_state", 1'b0, 3'd0, 3'd0, 16'd0);
    tick();

    // Load-use: exactly one stall cycle, then forward from entry 1
    do_reset(); idle(); issue(4'd5, 1'b1);
    check_now("lu_issue", 1'b0, 3'd0, 3'd0, 16'd0);
    tick();
    idle(); src1 = 4'd5; src1_valid = 1'b1;
    check_now("lu_stall", 1'b1, 3'd1, 3'd0, 16'd0);
    tick();
    check_now("lu_fwd", 1'b0, 3'd2, 3'd0, 16'd1);
    tick();
    idle();
    check_now("lu_drain", 1'b0, 3'd0, 3'd0, 16'd1);
    tick();

    // ALU forward on src2, gated by two_src and src1_valid
    do_reset(); idle(); issue(4'd2, 1'b0);
    check_now("alu_issue", 1'b0, 3'd0, 3'd0, 16'd0);
    tick();
    idle(); src1 = 4'd2; src2 = 4'd2; two_src = 1'b1;
    check_now("alu_src2", 1'b0, 3'd0, 3'd1, 16'd0);
    two_src = 1'b0;
    check_now("alu_nosrc2", 1'b0, 3'd0, 3'd0, 16'd0);
    tick();

    // Register 0 is an ordinary register
    idle(); issue(4'd0, 1'b0);
    tick();
    idle(); src1 = 4'd0; src1_valid = 1'b1;
    check_now("r0_fwd", 1'b0, 3'd1, 3'd0, 16'd0);
    tick();

    // Youngest writer wins: ALU in entry 0 hides the load in entry 1
    do_reset(); idle(); issue(4'd7, 1'b1);
    tick();
    issue(4'd7, 1'b0);
    tick();
    idle(); src1 = 4'd7; src1_valid = 1'b1; src2 = 4'd7; two_src = 1'b1;
    check_now("young", 1'b0, 3'd1, 3'd1, 16'd0);
    tick();

    // Flush alone squashes the ID writer
    do_reset(); idle(); issue(4'd9, 1'b0); flush = 1'b1;
    check_now("fl_issue", 1'b0, 3'd0, 3'd0, 16'd0);
    tick();
    idle(); src1 = 4'd9; src1_valid = 1'b1;
    check_now("fl_bubble", 1'b0, 3'd0, 3'd0, 16'd0);
    tick();

    // Flush together with a hazard: single bubble, counter still counts
    idle(); issue(4'd5, 1'b1);
    tick();
    idle(); src1 = 4'd5; src1_valid = 1'b1; issue(4'd6, 1'b0); flush = 1'b1;
    check_now("flh_stall", 1'b1, 3'd1, 3'd0, 16'd0);
    tick();
    idle(); src1 = 4'd6; src1_valid = 1'b1; src2 = 4'd5; two_src = 1'b1;
    check_now("flh_next", 1'b0, 3'd0, 3'd2, 16'd1);
    tick();

    // Freeze beats flush: entries hold
    do_reset(); idle();
    rr = 4'($urandom_range(8, 15));
    issue(rr, 1'b0);
    tick();
    idle(); freeze = 1'b1; flush = 1'b1; issue(rr ^ 4'd1, 1'b0);
    src1 = rr; src1_valid = 1'b1;
    check_now("ff_hold", 1'b0, 3'd1, 3'd0, 16'd0);
    tick();
    idle(); src1 = rr; src1_valid = 1'b1;
    check_now("ff_after", 1'b0, 3'd1, 3'd0, 16'd0);
    tick();

    // Asynchronous reset in the middle of traffic
    do_reset(); idle(); issue(4'd5, 1'b1);
    tick();
    idle(); src1 = 4'd5; src1_valid = 1'b1;
    check_now("mid_pre", 1'b1, 3'd1, 3'd0, 16'd0);
    tick();
    issue(4'd3, 1'b1);
    check_now("mid_pre2", 1'b0, 3'd2, 3'd0, 16'd1);
    rst = 1'b0;
    check_now("mid_rst", 1'b0, 3'd0, 3'd0, 16'd0);
    tick();
    rst = 1'b1;
    idle(); src1 = 4'd3; src1_valid = 1'b1;
    check_now("mid_after", 1'b0, 3'd0, 3'd0, 16'd0);
    tick();

    // No forwarding, STAGES=3: stall until the writer retires, freeze extends it
    dsel = 1;
    do_reset(); idle(); issue(4'd4, 1'b0);
    check_now("nf_issue", 1'b0, 3'd0, 3'd0, 16'd0);
    tick();
    idle(); src1 = 4'd4; src1_valid = 1'b1;
    check_now("nf_s1", 1'b1, 3'd0, 3'd0, 16'd0);
    tick();
    check_now("nf_s2", 1'b1, 3'd0, 3'd0, 16'd1);
    tick();
    freeze = 1'b1;
    check_now("nf_f1", 1'b1, 3'd0, 3'd0, 16'd2);
    tick();
    check_now("nf_f2", 1'b1, 3'd0, 3'd0, 16'd2);
    tick();
    freeze = 1'b0;
    check_now("nf_s3", 1'b1, 3'd0, 3'd0, 16'd2);
    tick();
    check_now("nf_done", 1'b0, 3'd0, 3'd0, 16'd3);
    tick();

    // Saturation with CNT_W=4: a self-dependent load chain stalls every other cycle
    dsel = 2;
    do_reset(); idle();
    exp_c = 0;
    for (int i = 0; i < 40; i++) begin
      idle(); issue(4'd6, 1'b1); src1 = 4'd6; src1_valid = 1'b1;
      h = (i % 2) == 1;
      s = (i == 0) ? 3'd0 : (h ? 3'd1 : 3'd2);
      check_now($sformatf("sat%0d", i), h, s, 3'd0, 16'(exp_c));
      if (h && exp_c < 15) exp_c++;
      tick();
    end
    idle();
    check_now("sat_hold", 1'b0, 3'd0, 3'd0, 16'd15);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
